// File: rtl/voxel_write_scheduler_if.sv
// Voxel memory write scheduler bus: generator stream, host queue port,
// flush handshake and the memory write port, grouped for one connection.
interface voxel_write_scheduler_if #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              gen_valid;
    logic              gen_ready;
    logic [ADDR_W-1:0] gen_addr;
    logic [DATA_W-1:0] gen_data;

    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;

    logic              frame_busy;
    logic              defer_en;
    logic              flush_req;
    logic              flush_done;

    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;

    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       host_commit_count;

    modport master (
        output gen_valid, gen_addr, gen_data,
        output host_valid, host_addr, host_data,
        output frame_busy, defer_en, flush_req,
        input  gen_ready, host_ready, flush_done,
        input  mem_write_en, mem_write_addr, mem_write_data,
        input  fifo_count, host_commit_count
    );

    modport slave (
        input  gen_valid, gen_addr, gen_data,
        input  host_valid, host_addr, host_data,
        input  frame_busy, defer_en, flush_req,
        output gen_ready, host_ready, flush_done,
        output mem_write_en, mem_write_addr, mem_write_data,
        output fifo_count, host_commit_count
    );
endinterface

// File: rtl/voxel_write_scheduler.sv
// Arbitrates voxel memory writes between the world generator and a
// deferrable host write queue, with a flush handshake for the host.
module voxel_write_scheduler #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    voxel_write_scheduler_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       LIMIT_C = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ARB,
        DRAIN,
        DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_starve_cnt;
    logic              r_flush_done;
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [31:0]       r_commit_cnt;

    logic w_not_empty;
    logic w_host_ready;
    logic w_push;
    logic w_starve;
    logic w_host_allowed;
    logic w_host_sel;
    logic w_gen_ready;
    logic w_gen_xfer;

    always_comb begin
        w_not_empty    = (r_count != '0);
        w_host_ready   = !rst && (r_count < DEPTH_C);
        w_push         = bus.host_valid && w_host_ready;
        w_starve       = bus.gen_valid && (r_starve_cnt == LIMIT_C);
        w_host_allowed = w_not_empty &&
                         ((r_state == DRAIN) ||
                          !(bus.defer_en && bus.frame_busy));
    end

    // Draining ignores both the defer window and generator starvation.
    always_comb begin
        w_host_sel = 1'b0;
        unique case (r_state)
            DRAIN:   w_host_sel = w_not_empty;
            default: w_host_sel = w_host_allowed && !w_starve;
        endcase
        if (rst) begin
            w_host_sel = 1'b0;
        end
    end

    always_comb begin
        w_gen_ready = !rst && !w_host_sel && (r_state == ARB);
        w_gen_xfer  = bus.gen_valid && w_gen_ready;
    end

    // Queue storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.host_addr;
            r_fifo_data[r_wr_ptr] <= bus.host_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve_cnt <= '0;
            r_flush_done <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_commit_cnt <= '0;
        end else begin
            r_flush_done <= 1'b0;
            r_mem_en     <= w_host_sel || w_gen_xfer;

            if (w_host_sel) begin
                r_mem_addr <= r_fifo_addr[r_rd_ptr];
                r_mem_data <= r_fifo_data[r_rd_ptr];
            end else if (w_gen_xfer) begin
                r_mem_addr <= bus.gen_addr;
                r_mem_data <= bus.gen_data;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_host_sel) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end

            unique case ({w_push, w_host_sel})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (!bus.gen_valid || w_gen_xfer) begin
                r_starve_cnt <= '0;
            end else if (w_host_sel && (r_starve_cnt != LIMIT_C)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end

            unique case (r_state)
                ARB: begin
                    if (bus.flush_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_count == '0) begin
                        r_state      <= DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= ARB;
                end
                default: begin
                    r_state <= ARB;
                end
            endcase
        end
    end

    assign bus.gen_ready         = w_gen_ready;
    assign bus.host_ready        = w_host_ready;
    assign bus.flush_done        = r_flush_done && !rst;
    assign bus.mem_write_en      = r_mem_en && !rst;
    assign bus.mem_write_addr    = rst ? '0 : r_mem_addr;
    assign bus.mem_write_data    = rst ? '0 : r_mem_data;
    assign bus.fifo_count        = rst ? '0 : r_count;
    assign bus.host_commit_count = r_commit_cnt;
endmodule

// File: tb/tb_voxel_write_scheduler.sv
// Scoreboard bench for voxel_write_scheduler: directed stimulus pushes
// expected memory writes, a negedge monitor pops and compares them.
module tb_voxel_write_scheduler;
    logic clk;
    logic rst;

    voxel_write_scheduler_if bus ();

    voxel_write_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [17:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] tb_mem [logic [17:0]];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] gdat(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [63:0] hdat(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input int a, input logic [63:0] d);
        wr_t e;
        e.a = 18'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic host_push(input int a, input logic [63:0] d);
        bus.host_valid = 1'b1;
        bus.host_addr  = 18'(a);
        bus.host_data  = d;
        expect_wr(a, d);
        tick();
        bus.host_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_write_en === 1'b1) begin
            tb_mem[bus.mem_write_addr] = bus.mem_write_data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                         bus.mem_write_addr, bus.mem_write_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_write_addr !== e.a || bus.mem_write_data !== e.d) begin
                    errors++;
                    $display("FAIL write_order: got %0h/%0h expected %0h/%0h",
                             bus.mem_write_addr, bus.mem_write_data, e.a, e.d);
                end
            end
        end
    end

    initial begin
        int h;
        rst            = 1'b1;
        bus.gen_valid  = 1'b0;
        bus.gen_addr   = '0;
        bus.gen_data   = '0;
        bus.host_valid = 1'b0;
        bus.host_addr  = '0;
        bus.host_data  = '0;
        bus.frame_busy = 1'b0;
        bus.defer_en   = 1'b0;
        bus.flush_req  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_mem_en", 64'(bus.mem_write_en), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_write_addr), 64'd0);
        chk("rst_mem_data", bus.mem_write_data, 64'd0);
        chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
        chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_gen_ready", 64'(bus.gen_ready), 64'd0);
        chk("rst_host_ready", 64'(bus.host_ready), 64'd0);
        chk("rst_commits", 64'(bus.host_commit_count), 64'd0);
        rst = 1'b0;
        tick();

        // Generator only: 100 back-to-back writes
        bus.gen_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.gen_addr = 18'(i);
            bus.gen_data = gdat(i);
            expect_wr(i, gdat(i));
            #1;
            chk("gen_ready", 64'(bus.gen_ready), 64'd1);
            tick();
            chk("gen_latency_en", 64'(bus.mem_write_en), 64'd1);
            chk("gen_latency_addr", 64'(bus.mem_write_addr), 64'(i));
        end
        bus.gen_valid = 1'b0;
        tick();
        chk("gen_idle", 64'(bus.mem_write_en), 64'd0);

        // Queue full while deferred
        bus.defer_en   = 1'b1;
        bus.frame_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("full_ready", 64'(bus.host_ready), 64'd1);
            host_push(100 + i, hdat(100 + i));
        end
        chk("full_count", 64'(bus.fifo_count), 64'd8);
        chk("full_host_ready", 64'(bus.host_ready), 64'd0);
        chk("full_commits", 64'(bus.host_commit_count), 64'd0);
        bus.host_valid = 1'b1;
        bus.host_addr  = 18'd999;
        bus.host_data  = 64'hDEAD;
        tick();
        bus.host_valid = 1'b0;
        chk("full_no_push", 64'(bus.fifo_count), 64'd8);
        tick();
        chk("defer_no_write", 64'(bus.mem_write_en), 64'd0);
        bus.frame_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("undefer_en", 64'(bus.mem_write_en), 64'd1);
            chk("undefer_addr", 64'(bus.mem_write_addr), 64'(100 + i));
        end
        tick();
        chk("undefer_idle", 64'(bus.mem_write_en), 64'd0);
        chk("undefer_count", 64'(bus.fifo_count), 64'd0);
        chk("undefer_commits", 64'(bus.host_commit_count), 64'd8);
        bus.defer_en = 1'b0;

        // Starvation: one generator slot after every 16 host pops
        h = 0;
        for (int k = 0; k < 52; k++) begin
            if (k % 17 == 0) expect_wr(200 + k / 17, gdat(200 + k / 17));
            else begin
                expect_wr(300 + h, hdat(300 + h));
                h++;
            end
        end
        for (int p = 48; p < 52; p++) expect_wr(300 + p, hdat(300 + p));
        for (int k = 0; k < 52; k++) begin
            bus.gen_valid  = 1'b1;
            bus.gen_addr   = 18'(200 + (k + 16) / 17);
            bus.gen_data   = gdat(200 + (k + 16) / 17);
            bus.host_valid = 1'b1;
            bus.host_addr  = 18'(300 + k);
            bus.host_data  = hdat(300 + k);
            #1;
            chk("starve_slot", 64'(bus.gen_ready), (k % 17 == 0) ? 64'd1 : 64'd0);
            tick();
        end
        bus.gen_valid  = 1'b0;
        bus.host_valid = 1'b0;
        repeat (8) tick();
        chk("starve_drained", 64'(bus.fifo_count), 64'd0);

        // Flush with 5 deferred writes
        bus.defer_en   = 1'b1;
        bus.frame_busy = 1'b1;
        for (int i = 0; i < 5; i++) host_push(400 + i, hdat(400 + i));
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        bus.gen_valid = 1'b1;
        bus.gen_addr  = 18'd500;
        bus.gen_data  = gdat(500);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("drain_gen_ready", 64'(bus.gen_ready), 64'd0);
            tick();
            chk("drain_write", 64'(bus.mem_write_en), 64'd1);
            chk("drain_no_done", 64'(bus.flush_done), 64'd0);
        end
        chk("drain_gen_ready_last", 64'(bus.gen_ready), 64'd0);
        tick();
        chk("flush_done_pulse", 64'(bus.flush_done), 64'd1);
        chk("done_gen_ready", 64'(bus.gen_ready), 64'd0);
        expect_wr(500, gdat(500));
        tick();
        chk("flush_done_fall", 64'(bus.flush_done), 64'd0);
        chk("arb_resume", 64'(bus.gen_ready), 64'd1);
        tick();
        bus.gen_valid = 1'b0;
        tick();

        // Flush with an empty queue
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        chk("eflush_c1", 64'(bus.flush_done), 64'd0);
        tick();
        chk("eflush_c2", 64'(bus.flush_done), 64'd1);
        tick();
        chk("eflush_c3", 64'(bus.flush_done), 64'd0);

        // Simultaneous push and pop at count 4
        for (int i = 0; i < 4; i++) host_push(600 + i, hdat(600 + i));
        chk("pp_count_before", 64'(bus.fifo_count), 64'd4);
        bus.frame_busy = 1'b0;
        host_push(604, hdat(604));
        chk("pp_count_after", 64'(bus.fifo_count), 64'd4);
        repeat (5) tick();
        chk("pp_drained", 64'(bus.fifo_count), 64'd0);
        bus.defer_en = 1'b0;

        // Same-address host then generator: generator data lands last
        host_push(700, hdat(700));
        tick();
        bus.gen_valid = 1'b1;
        bus.gen_addr  = 18'd700;
        bus.gen_data  = gdat(700);
        expect_wr(700, gdat(700));
        tick();
        bus.gen_valid = 1'b0;
        repeat (2) tick();
        chk("collision_exists", 64'(tb_mem.exists(18'd700)), 64'd1);
        if (tb_mem.exists(18'd700)) chk("collision_data", tb_mem[18'd700], gdat(700));
        chk("total_commits", 64'(bus.host_commit_count), 64'd71);

        // Reset mid-drain with 3 entries queued
        bus.defer_en   = 1'b1;
        bus.frame_busy = 1'b1;
        for (int i = 0; i < 3; i++) host_push(800 + i, hdat(800 + i));
        for (int i = 0; i < 3; i++) void'(exp_q.pop_back());
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        chk("mid_drain_count", 64'(bus.fifo_count), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_host_ready_comb", 64'(bus.host_ready), 64'd0);
        chk("rst_gen_ready_comb", 64'(bus.gen_ready), 64'd0);
        tick();
        chk("rstd_mem_en", 64'(bus.mem_write_en), 64'd0);
        chk("rstd_count", 64'(bus.fifo_count), 64'd0);
        chk("rstd_flush_done", 64'(bus.flush_done), 64'd0);
        chk("rstd_commits", 64'(bus.host_commit_count), 64'd0);
        rst = 1'b0;
        bus.defer_en   = 1'b0;
        bus.frame_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_done", 64'(bus.flush_done), 64'd0);
            chk("post_rst_en", 64'(bus.mem_write_en), 64'd0);
        end
        chk("post_rst_commits", 64'(bus.host_commit_count), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
